score_scan: RTL

Downstream display stage for the light-pong game. Takes the two player scores produced by the game core, converts each to two decimal digits, and time-multiplexes them across the board's eight common-anode 7-segment digits. Also supports a frame-synchronous "point flash" that blinks the score digits for a programmable number of scan frames.

---
 rtl/light_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 27 ++
 rtl/score_scan.sv | 102 ++++++++++
 3 files changed

// File: rtl/light_pkg.sv
// Shared constants and helpers for the light-pong display path.
// Segment patterns are active-low, a..g with a as the MSB.
package light_pkg;

    localparam logic [6:0] SEG_BLANK   = 7'b1111111;
    localparam int         NUM_DIGITS  = 8;
    localparam int         POS_S1_ONES = 0;
    localparam int         POS_S1_TENS = 1;
    localparam int         POS_S2_ONES = 4;
    localparam int         POS_S2_TENS = 5;

    typedef struct packed {
        logic       tens;
        logic [3:0] ones;
    } dec_t;

    // Scores never exceed 15, so a single compare-and-subtract is enough.
    function automatic dec_t split_score(input logic [3:0] v);
        dec_t d;
        d.tens = (v >= 4'd10);
        d.ones = d.tens ? (v - 4'd10) : v;
        return d;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit digit to active-low a..g segment decoder.
// Codes 10..15 decode to blank.
module seg7_decode
    import light_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = 7'b0000001;
            4'd1: seg = 7'b1001111;
            4'd2: seg = 7'b0010010;
            4'd3: seg = 7'b0000110;
            4'd4: seg = 7'b1001100;
            4'd5: seg = 7'b0100100;
            4'd6: seg = 7'b0100000;
            4'd7: seg = 7'b0001111;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_scan.sv
// Latches two scores and scans them across eight 7-segment digits.
// Outputs are registered one cycle behind the scan index; flash blanks whole frames.
module score_scan
    import light_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int FLASH_FRAMES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] score1,
    input  logic [3:0] score2,
    input  logic       load,
    input  logic       flash,
    output logic [7:0] an,
    output logic [6:0] a_g,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [3:0]    s1_q;
    logic [3:0]    s2_q;
    logic [FW-1:0] fl_cnt;

    logic          wrap;
    logic          frame_end;
    logic          blank_fl;
    logic          lit;
    logic [3:0]    digit;
    logic [6:0]    seg;
    logic [7:0]    an_nxt;
    logic [6:0]    a_g_nxt;
    dec_t          d1;
    dec_t          d2;

    assign wrap      = (cnt == CW'(REFRESH_DIV - 1));
    assign frame_end = wrap && (idx == IW'(NUM_DIGITS - 1));
    assign blank_fl  = (fl_cnt != '0) && fl_cnt[0];
    assign d1        = split_score(s1_q);
    assign d2        = split_score(s2_q);
    assign dp        = 1'b1;

    // Blank positions feed an out-of-range code so the decoder blanks them.
    always_comb begin
        lit   = 1'b0;
        digit = 4'hF;
        case (idx)
            IW'(POS_S1_ONES): begin lit = 1'b1;    digit = d1.ones;         end
            IW'(POS_S1_TENS): begin lit = d1.tens; digit = {3'b000, d1.tens}; end
            IW'(POS_S2_ONES): begin lit = 1'b1;    digit = d2.ones;         end
            IW'(POS_S2_TENS): begin lit = d2.tens; digit = {3'b000, d2.tens}; end
            default:          begin lit = 1'b0;    digit = 4'hF;            end
        endcase
    end

    seg7_decode u_dec (
        .digit (digit),
        .seg   (seg)
    );

    always_comb begin
        an_nxt  = 8'hFF;
        a_g_nxt = SEG_BLANK;
        if (lit && !blank_fl) begin
            an_nxt  = ~(8'b1 << idx);
            a_g_nxt = seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            idx    <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            fl_cnt <= '0;
            an     <= 8'hFF;
            a_g    <= SEG_BLANK;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap)
                idx <= idx + 1'b1;
            if (load) begin
                s1_q <= score1;
                s2_q <= score2;
            end
            // A new strobe reloads even on a frame-end cycle.
            if (flash)
                fl_cnt <= FW'(FLASH_FRAMES);
            else if (frame_end && fl_cnt != '0)
                fl_cnt <= fl_cnt - 1'b1;
            an  <= an_nxt;
            a_g <= a_g_nxt;
        end
    end

endmodule
